systolic_skew_feeder: RTL and testbench
=======================================

Name: systolic_skew_feeder

Overview:
Input stage sitting directly upstream of the N x N pe grid. Accepts one K-step per beat: a column of A (one element per grid row) and a row of B (one element per grid column). Applies the triangular skew the grid needs (lane i delayed i cycles), drives the west and north edges, and injects zeros when idle or stalled, since a PE treats zero as a bubble. After the last beat it flushes the grid and pulses done once all PE results are final.

Parameters:
N, 4, grid dimension (rows = cols = lanes per edge)
DATA_WIDTH, 8, element width; matches the pe DATA_WIDTH
K_W, 16, width of the k_len operand

Ports:
clk  in  1  clock
rst  in  1  reset
start  in  1  launch one matmul pass; sampled only in IDLE
k_len  in  K_W  number of K-steps (beats) in the pass; captured on start
s_valid  in  1  beat valid
s_ready  out  1  beat ready
s_a_col  in  N*DATA_WIDTH  lane i = A[i][k], lane 0 in LSBs
s_b_row  in  N*DATA_WIDTH  lane j = B[k][j], lane 0 in LSBs
west_out  out  N*DATA_WIDTH  lane i drives inp_west of pe row i, column 0
north_out  out  N*DATA_WIDTH  lane j drives inp_north of pe row 0, column j
busy  out  1  high in LOAD, FLUSH and DONE
done  out  1  one-cycle pulse; grid results are final

Behaviour:
- Reset: rst is asynchronous, active-high; clk is the clock. All skew registers are 0. west_out=0, north_out=0, s_ready=0, busy=0, done=0. FSM is IDLE.
- FSM states: IDLE, LOAD, FLUSH, DONE.
- IDLE:
  - start=1 and k_len!=0: capture k_len, clear beat_cnt, go to LOAD.
  - start=1 and k_len==0: go directly to DONE. No data is driven.
- LOAD:
  - s_ready=1.
  - A beat is accepted when s_valid & s_ready; beat_cnt increments.
  - Beat accepted on cycle t: west_out lane i = A lane i on cycle t+1+i, north_out lane j = B lane j on cycle t+1+j.
  - Lane 0 has one register stage; lane i has i+1 stages.
  - No beat on cycle t (s_valid=0): zeros enter every lane's first stage. This is a legal bubble.
  - Acceptance of beat k_len-1: go to FLUSH, load flush_cnt = 2N-1.
- FLUSH:
  - s_ready=0. Zeros enter all lanes; skew registers keep shifting.
  - flush_cnt decrements each cycle. At 0, go to DONE.
  - Timing: the last beat is accepted on cycle L. DONE is entered on cycle L+2N, so done is high during cycle L+2N. By then PE(N-1,N-1) has registered its final accumulation, on the edge ending cycle L+2N-1.
- DONE: done=1 for exactly one cycle, then IDLE. busy=1 in this cycle.
- start while busy is ignored. k_len changes while busy are ignored.
- s_valid asserted in IDLE, FLUSH or DONE is not accepted (s_ready=0).
- No arithmetic is performed. Data is passed bit-exact and unsigned-agnostic.
- Zero-valued operands are transmitted unchanged. The pe's zero-skip then contributes nothing, which is numerically identical to accumulating a zero product.
- The feeder does not clear PE accumulators. Between passes, the grid is cleared by rst only.
- rst asserted mid-LOAD or mid-FLUSH: everything returns immediately to reset values. No done is generated for the aborted pass.

Optional Feature:
FEEDER_STALL_CNT_EN
- Defined:
  - Adds output port stall_cnt [15:0].
  - Counts LOAD cycles with s_valid=0.
  - Saturates at 16'hFFFF.
  - Cleared to 0 when start is accepted and on rst.
  - Holds its value after done.
- Undefined: the port and its counter are absent. All other behaviour is identical.

Test Plan:
- Reset, N=4: with no start, hold 10 cycles -> west_out=0, north_out=0, s_ready=0, busy=0, done=0 throughout.
- Skew timing, N=4: start, k_len=1; beat A=[1,2,3,4], B=[5,6,7,8] accepted on cycle t -> west lanes 0..3 = 1,2,3,4 on cycles t+1..t+4 respectively, north lanes = 5..8 on the same cycles, zero otherwise; done on cycle t+8.
- Full 4x4 pass with grid attached: k_len=4, A=I, B rows=[1..4],[5..8],[9..12],[13..16] -> at done, result[i][j] = B[i][j].
- Stall: k_len=3, s_valid low for 2 cycles between beats 1 and 2 -> bubbles are zeros, done is 2N cycles after the third beat, grid result is unchanged versus the no-stall run; with FEEDER_STALL_CNT_EN, stall_cnt=2.
- Edge cases:
  - start with k_len=0 -> done pulses on the next cycle; no nonzero output.
  - start pulsed during FLUSH -> ignored; exactly one done.
- Reset mid-LOAD after 2 of 4 beats -> outputs zero on the next clk edge, state IDLE, no done; a new start then completes normally.

Source files
------------

// File: rtl/systolic_skew_feeder_if.sv
// Beat stream into the systolic skew feeder: one K-step per beat, A column plus B row.
interface systolic_skew_feeder_if #(
  parameter int N          = 4,
  parameter int DATA_WIDTH = 8
);
  logic                    s_valid;
  logic                    s_ready;
  logic [N*DATA_WIDTH-1:0] s_a_col;
  logic [N*DATA_WIDTH-1:0] s_b_row;

  modport master (output s_valid, output s_a_col, output s_b_row, input s_ready);
  modport slave  (input s_valid, input s_a_col, input s_b_row, output s_ready);
endinterface

// File: rtl/systolic_skew_feeder.sv
// Triangular-skew input stage for an N x N PE grid; flushes with zeros and pulses done.
// Optional stall counter output is enabled by defining FEEDER_STALL_CNT_EN.
module systolic_skew_feeder #(
  parameter int N          = 4,
  parameter int DATA_WIDTH = 8,
  parameter int K_W        = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [K_W-1:0]          k_len,
  systolic_skew_feeder_if.slave   s,
  output logic [N*DATA_WIDTH-1:0] west_out,
  output logic [N*DATA_WIDTH-1:0] north_out,
  output logic                    busy,
  output logic                    done
`ifdef FEEDER_STALL_CNT_EN
  ,
  output logic [15:0]             stall_cnt
`endif
);

  localparam int FLUSH_W = $clog2(2 * N) + 1;
  localparam logic [FLUSH_W-1:0] FLUSH_INIT = FLUSH_W'(2 * N - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             state_r;
  state_t             state_nxt_s;
  logic [K_W-1:0]     k_len_r;
  logic [K_W-1:0]     beat_cnt_r;
  logic [FLUSH_W-1:0] flush_cnt_r;
  logic               ready_r;
  logic               busy_r;
  logic               done_r;
  logic               fire_s;
  logic               last_beat_s;

  assign fire_s      = (state_r == LOAD) && s.s_valid;
  assign last_beat_s = (beat_cnt_r == (k_len_r - K_W'(1)));
  assign s.s_ready   = ready_r;
  assign busy        = busy_r;
  assign done        = done_r;

  // State register plus flag flops decoded from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      ready_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      ready_r <= (state_nxt_s == LOAD);
      busy_r  <= (state_nxt_s != IDLE);
      done_r  <= (state_nxt_s == DONE);
    end
  end

  // Next-state logic; flush ends when the counter is about to reach zero so DONE lands 2N after the last beat.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          if (k_len != K_W'(0)) begin
            state_nxt_s = LOAD;
          end else begin
            state_nxt_s = DONE;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      LOAD: begin
        if (fire_s && last_beat_s) begin
          state_nxt_s = FLUSH;
        end else begin
          state_nxt_s = LOAD;
        end
      end
      FLUSH: begin
        if (flush_cnt_r == FLUSH_W'(1)) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = FLUSH;
        end
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Pass bookkeeping: captured length, accepted beats, remaining flush cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k_len_r     <= '0;
      beat_cnt_r  <= '0;
      flush_cnt_r <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            k_len_r    <= k_len;
            beat_cnt_r <= '0;
          end
        end
        LOAD: begin
          if (fire_s) begin
            beat_cnt_r <= beat_cnt_r + K_W'(1);
            if (last_beat_s) begin
              flush_cnt_r <= FLUSH_INIT;
            end
          end
        end
        FLUSH:   flush_cnt_r <= flush_cnt_r - FLUSH_W'(1);
        default: ;
      endcase
    end
  end

`ifdef FEEDER_STALL_CNT_EN
  logic [15:0] stall_cnt_r;
  assign stall_cnt = stall_cnt_r;

  // Saturating count of LOAD cycles without a beat; held after done until the next start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_r <= 16'h0000;
    end else if ((state_r == IDLE) && start) begin
      stall_cnt_r <= 16'h0000;
    end else if ((state_r == LOAD) && !s.s_valid && (stall_cnt_r != 16'hFFFF)) begin
      stall_cnt_r <= stall_cnt_r + 16'h0001;
    end
  end
`endif

  // Lane i carries i+1 register stages; zero enters whenever no beat is accepted.
  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [DATA_WIDTH-1:0] west_sr_r  [0:i];
    logic [DATA_WIDTH-1:0] north_sr_r [0:i];

    // Skew shift registers for west lane i and north lane i.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int k = 0; k <= i; k++) begin
          west_sr_r[k]  <= '0;
          north_sr_r[k] <= '0;
        end
      end else begin
        west_sr_r[0]  <= fire_s ? s.s_a_col[i*DATA_WIDTH +: DATA_WIDTH] : '0;
        north_sr_r[0] <= fire_s ? s.s_b_row[i*DATA_WIDTH +: DATA_WIDTH] : '0;
        for (int k = 1; k <= i; k++) begin
          west_sr_r[k]  <= west_sr_r[k-1];
          north_sr_r[k] <= north_sr_r[k-1];
        end
      end
    end

    assign west_out[i*DATA_WIDTH +: DATA_WIDTH]  = west_sr_r[i];
    assign north_out[i*DATA_WIDTH +: DATA_WIDTH] = north_sr_r[i];
  end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Directed bench for systolic_skew_feeder with a behavioural 4x4 PE grid on its edges.
module tb_systolic_skew_feeder;
  localparam int N  = 4;
  localparam int DW = 8;

  logic            clk;
  logic            rst;
  logic            start;
  logic [15:0]     k_len;
  logic [N*DW-1:0] west_out;
  logic [N*DW-1:0] north_out;
  logic            busy;
  logic            done;
`ifdef FEEDER_STALL_CNT_EN
  logic [15:0]     stall_cnt;
`endif

  systolic_skew_feeder_if #(.N(N), .DATA_WIDTH(DW)) bus ();

  systolic_skew_feeder #(.N(N), .DATA_WIDTH(DW), .K_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .k_len     (k_len),
    .s         (bus),
    .west_out  (west_out),
    .north_out (north_out),
    .busy      (busy),
    .done      (done)
`ifdef FEEDER_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural PE grid: operands flow east/south one PE per cycle, products accumulate.
  logic [DW-1:0] wr [N][N];
  logic [DW-1:0] nr [N][N];
  int            acc [N][N];

  function automatic logic [DW-1:0] ain(int i, int j);
    if (j == 0) return west_out[i*DW +: DW];
    else return wr[i][j-1];
  endfunction

  function automatic logic [DW-1:0] bin(int i, int j);
    if (i == 0) return north_out[j*DW +: DW];
    else return nr[i-1][j];
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          acc[i][j] <= 0;
          wr[i][j]  <= '0;
          nr[i][j]  <= '0;
        end
    end else begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          acc[i][j] <= acc[i][j] + int'(ain(i, j)) * int'(bin(i, j));
          wr[i][j]  <= ain(i, j);
          nr[i][j]  <= bin(i, j);
        end
    end
  end

  int tests;
  int fails;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic beat(input logic [31:0] a, input logic [31:0] b);
    bus.s_valid = 1'b1;
    bus.s_a_col = a;
    bus.s_b_row = b;
    tick();
    bus.s_valid = 1'b0;
    bus.s_a_col = '0;
    bus.s_b_row = '0;
  endtask

  // Called on the cycle after the last beat; returns cycles from the last beat to done.
  task automatic wait_done(input int first, output int lat);
    lat = first;
    while (!done && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  logic [31:0] exp_w [0:9];
  logic [31:0] exp_n [0:9];
  int          lat;
  int          extra;

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    start = 1'b0;
    k_len = '0;
    bus.s_valid = 1'b0;
    bus.s_a_col = '0;
    bus.s_b_row = '0;
    for (int d = 0; d <= 9; d++) begin
      exp_w[d] = 32'h0;
      exp_n[d] = 32'h0;
    end
    exp_w[1] = 32'h00000001; exp_n[1] = 32'h00000005;
    exp_w[2] = 32'h00000200; exp_n[2] = 32'h00000600;
    exp_w[3] = 32'h00030000; exp_n[3] = 32'h00070000;
    exp_w[4] = 32'h04000000; exp_n[4] = 32'h08000000;
    #2;
    do_reset();

    // Idle after reset with no start.
    for (int c = 0; c < 10; c++) begin
      chk("reset_data", {west_out, north_out}, 64'h0);
      chk("reset_ctl", {bus.s_ready, busy, done}, 64'h0);
      tick();
    end

    // Single beat: skew timing and done at t+8.
    start = 1'b1; k_len = 16'd1;
    tick();
    start = 1'b0;
    chk("skew_ready", bus.s_ready, 64'h1);
    beat(32'h04030201, 32'h08070605);
    for (int d = 1; d <= 9; d++) begin
      chk($sformatf("skew_west_t%0d", d), west_out, exp_w[d]);
      chk($sformatf("skew_north_t%0d", d), north_out, exp_n[d]);
      chk($sformatf("skew_done_t%0d", d), done, (d == 8) ? 64'h1 : 64'h0);
      if (d < 9) tick();
    end
    chk("skew_idle_busy", busy, 64'h0);

    // Zero-length pass: done the very next cycle, nothing driven.
    start = 1'b1; k_len = 16'd0;
    tick();
    start = 1'b0;
    chk("k0_done", {busy, done}, 64'h3);
    chk("k0_data", {west_out, north_out}, 64'h0);
    tick();
    chk("k0_after", {busy, done}, 64'h0);

    // Reset mid-LOAD after 2 of 4 beats.
    start = 1'b1; k_len = 16'd4;
    tick();
    start = 1'b0;
    beat(32'hFFFFFFFF, 32'hFFFFFFFF);
    beat(32'hFFFFFFFF, 32'hFFFFFFFF);
    rst = 1'b1;
    tick();
    chk("abort_data", {west_out, north_out}, 64'h0);
    chk("abort_ctl", {bus.s_ready, busy, done}, 64'h0);
    rst = 1'b0;
    extra = 0;
    for (int c = 0; c < 12; c++) begin
      if (done) extra++;
      tick();
    end
    chk("abort_no_done", extra, 64'h0);

    // Identity pass: result equals B; start pulsed during FLUSH is ignored.
    start = 1'b1; k_len = 16'd4;
    tick();
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("id_ready_%0d", k), bus.s_ready, 64'h1);
      beat(32'h1 << (8 * k),
           {8'(4*k+4), 8'(4*k+3), 8'(4*k+2), 8'(4*k+1)});
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(2, lat);
    chk("id_done_latency", lat, 64'd8);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        chk($sformatf("id_c%0d%0d", i, j), acc[i][j], 64'(4*i + j + 1));
    extra = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (done) extra++;
    end
    chk("flush_start_extra_done", extra, 64'h0);
    chk("flush_start_busy", busy, 64'h0);

    // Stall: two bubbles between beats 1 and 2.
    do_reset();
    start = 1'b1; k_len = 16'd3;
    tick();
    start = 1'b0;
    beat(32'h04030201, 32'h04030201);
    beat(32'h05040302, 32'h04030201);
    tick();
    chk("stall_west_c4", west_out, 64'h00030300);
    chk("stall_north_c4", north_out, 64'h00030200);
    tick();
    chk("stall_lane0_c5", {west_out[7:0], north_out[7:0]}, 64'h0);
    beat(32'h06050403, 32'h04030201);
    wait_done(1, lat);
    chk("stall_done_latency", lat, 64'd8);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        chk($sformatf("stall_c%0d%0d", i, j), acc[i][j], 64'((j + 1) * (3*i + 6)));
`ifdef FEEDER_STALL_CNT_EN
    chk("stall_cnt", stall_cnt, 64'd2);
    tick();
    chk("stall_cnt_hold", stall_cnt, 64'd2);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
